// File: rtl/fifo_byte_serializer_if.sv
// Bundle for the serializer's FIFO-side pop port and its valid/ready beat stream.
// The slave modport is the serializer's view of the bus. The master modport is the view of whatever drives it.
interface fifo_byte_serializer_if #(
   parameter int FWIDTH = 32,
   parameter int OWIDTH = 8,
   parameter int CNTW   = 16
);
   logic              FlushN;
   logic              En;
   logic [FWIDTH-1:0] F_Data;
   logic              F_EmptyN;
   logic              FOutN;
   logic [OWIDTH-1:0] Out_Data;
   logic              Out_Valid;
   logic              Out_Ready;
   logic              Out_Last;
   logic [CNTW-1:0]   Pop_Cnt;

   modport master (
      output FlushN, En, F_Data, F_EmptyN, Out_Ready,
      input  FOutN, Out_Data, Out_Valid, Out_Last, Pop_Cnt
   );

   modport slave (
      input  FlushN, En, F_Data, F_EmptyN, Out_Ready,
      output FOutN, Out_Data, Out_Valid, Out_Last, Pop_Cnt
   );
endinterface

// File: rtl/fifo_byte_serializer.sv
// Drains 32-bit FIFO words and sends each one out as OWIDTH-bit beats on a valid/ready stream.
// The next word is popped while the last beat is accepted, so a non-empty FIFO gives output with no bubbles.
module fifo_byte_serializer #(
   parameter int FWIDTH    = 32,
   parameter int OWIDTH    = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNTW      = 16
) (
   input  logic                   Clk,
   input  logic                   RstN,
   fifo_byte_serializer_if.slave  bus
);
   localparam int RATIO = FWIDTH / OWIDTH;
   localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

   if ((FWIDTH % OWIDTH) != 0) begin : g_width_check
      $error("fifo_byte_serializer: FWIDTH must be an integer multiple of OWIDTH");
   end

   typedef enum logic {
      EMPTY = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [FWIDTH-1:0] word_q, word_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [CNTW-1:0]   pop_cnt_q, pop_cnt_d;

   logic              hold;
   logic              acc;
   logic              last;
   logic              pop;
   logic [IDXW-1:0]   sel;
   logic [OWIDTH-1:0] beats [RATIO];

   for (genvar k = 0; k < RATIO; k++) begin : g_beats
      assign beats[k] = word_q[k*OWIDTH +: OWIDTH];
   end

   assign hold = (state_q == SHIFT);
   assign acc  = hold & bus.Out_Ready;
   assign last = (idx_q == LAST_IDX);
   assign pop  = bus.FlushN & bus.En & bus.F_EmptyN & (~hold | (acc & last));
   // Beat 0 is the top slice of the word when MSB_FIRST is set, so the index counts down through the slices.
   assign sel  = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

   assign bus.FOutN     = ~(pop & RstN);
   assign bus.Out_Valid = hold;
   assign bus.Out_Last  = hold & last;
   assign bus.Out_Data  = hold ? beats[sel] : '0;
   assign bus.Pop_Cnt   = pop_cnt_q;

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      idx_d     = idx_q;
      pop_cnt_d = pop_cnt_q;
      if (!bus.FlushN) begin
         state_d   = EMPTY;
         idx_d     = '0;
         pop_cnt_d = '0;
      end else if (pop) begin
         // A pop either fills an empty stage or reloads it on the last beat. Either way it starts a new word.
         word_d    = bus.F_Data;
         idx_d     = '0;
         state_d   = SHIFT;
         pop_cnt_d = pop_cnt_q + CNTW'(1);
      end else if (acc) begin
         if (last) begin
            state_d = EMPTY;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IDXW'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q   <= EMPTY;
         word_q    <= '0;
         idx_q     <= '0;
         pop_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         pop_cnt_q <= pop_cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer. An MSB-first copy and an LSB-first copy share a single FIFO model and the same inputs.
// A beat scoreboard is loaded at each modelled pop, and every accepted beat is checked against it.
module tb_fifo_byte_serializer;
   localparam int FW = 32;
   localparam int OW = 8;
   localparam int CW = 16;

   typedef struct packed {
      logic [7:0] m;
      logic [7:0] l;
      logic       last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        flush_n;
   logic        en;
   logic        f_empty_n;
   logic        out_ready;
   logic [31:0] f_data;

   logic [31:0] fifo_q[$];
   beat_t       exp_q[$];
   logic [15:0] cnt_model;
   int          n_checks;
   int          n_pass;

   logic        d_v, d_f, d_l;
   logic [7:0]  d_m, d_lsb;

   fifo_byte_serializer_if #(.FWIDTH(FW), .OWIDTH(OW), .CNTW(CW)) bus_m ();
   fifo_byte_serializer_if #(.FWIDTH(FW), .OWIDTH(OW), .CNTW(CW)) bus_l ();

   assign bus_m.FlushN    = flush_n;
   assign bus_m.En        = en;
   assign bus_m.F_Data    = f_data;
   assign bus_m.F_EmptyN  = f_empty_n;
   assign bus_m.Out_Ready = out_ready;
   assign bus_l.FlushN    = flush_n;
   assign bus_l.En        = en;
   assign bus_l.F_Data    = f_data;
   assign bus_l.F_EmptyN  = f_empty_n;
   assign bus_l.Out_Ready = out_ready;

   fifo_byte_serializer #(.FWIDTH(FW), .OWIDTH(OW), .MSB_FIRST(1'b1), .CNTW(CW)) dut_msb (
      .Clk  (clk),
      .RstN (rst_n),
      .bus  (bus_m)
   );

   fifo_byte_serializer #(.FWIDTH(FW), .OWIDTH(OW), .MSB_FIRST(1'b0), .CNTW(CW)) dut_lsb (
      .Clk  (clk),
      .RstN (rst_n),
      .bus  (bus_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // An empty FIFO shows a junk head word, so any capture of it shows up on the scoreboard.
   task automatic refresh_head();
      f_empty_n = (fifo_q.size() != 0);
      f_data    = f_empty_n ? fifo_q[0] : 32'hDEAD_BEEF;
   endtask

   task automatic push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      refresh_head();
   endtask

   // One clock: check outputs against the model at negedge, then move the FIFO and scoreboard on at posedge.
   task automatic advance_cycle(output logic o_valid, output logic o_fout_n,
                                output logic [7:0] o_data_m, output logic [7:0] o_data_l,
                                output logic o_last);
      logic        exp_valid;
      logic        exp_pop;
      beat_t       b;
      logic [31:0] w;
      @(negedge clk);
      exp_valid = (exp_q.size() != 0);
      exp_pop   = flush_n && en && (fifo_q.size() != 0) &&
                  (!exp_valid || (out_ready && (exp_q.size() == 1)));
      o_valid   = bus_m.Out_Valid;
      o_fout_n  = bus_m.FOutN;
      o_data_m  = bus_m.Out_Data;
      o_data_l  = bus_l.Out_Data;
      o_last    = bus_m.Out_Last;

      n_checks++;
      if (bus_m.Out_Valid !== exp_valid || bus_l.Out_Valid !== exp_valid)
         $display("[TB] FAIL out_valid: msb=%b lsb=%b expected %b at %0t",
                  bus_m.Out_Valid, bus_l.Out_Valid, exp_valid, $time);
      else n_pass++;

      n_checks++;
      if (bus_m.FOutN !== !exp_pop || bus_l.FOutN !== !exp_pop)
         $display("[TB] FAIL fout_n: msb=%b lsb=%b expected %b at %0t",
                  bus_m.FOutN, bus_l.FOutN, !exp_pop, $time);
      else n_pass++;

      n_checks++;
      if (bus_m.Pop_Cnt !== cnt_model || bus_l.Pop_Cnt !== cnt_model)
         $display("[TB] FAIL pop_cnt: msb=%0d lsb=%0d expected %0d at %0t",
                  bus_m.Pop_Cnt, bus_l.Pop_Cnt, cnt_model, $time);
      else n_pass++;

      n_checks++;
      if (exp_valid) begin
         b = exp_q[0];
         if (bus_m.Out_Data !== b.m || bus_l.Out_Data !== b.l ||
             bus_m.Out_Last !== b.last || bus_l.Out_Last !== b.last)
            $display("[TB] FAIL beat: msb=%h/%b lsb=%h/%b expected %h/%b and %h/%b at %0t",
                     bus_m.Out_Data, bus_m.Out_Last, bus_l.Out_Data, bus_l.Out_Last,
                     b.m, b.last, b.l, b.last, $time);
         else n_pass++;
      end else begin
         if (bus_m.Out_Data !== 8'h00 || bus_l.Out_Data !== 8'h00 ||
             bus_m.Out_Last !== 1'b0 || bus_l.Out_Last !== 1'b0)
            $display("[TB] FAIL idle_data: msb=%h/%b lsb=%h/%b expected 00/0 at %0t",
                     bus_m.Out_Data, bus_m.Out_Last, bus_l.Out_Data, bus_l.Out_Last, $time);
         else n_pass++;
      end

      @(posedge clk);
      if (!flush_n) begin
         exp_q.delete();
         cnt_model = 16'd0;
      end else begin
         if (exp_valid && out_ready) void'(exp_q.pop_front());
         if (exp_pop) begin
            w = fifo_q[0];
            for (int k = 0; k < 4; k++) begin
               b.m    = w[31-8*k -: 8];
               b.l    = w[8*k +: 8];
               b.last = (k == 3);
               exp_q.push_back(b);
            end
            void'(fifo_q.pop_front());
            cnt_model = cnt_model + 16'd1;
         end
      end
      #1;
      refresh_head();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && fifo_q.size() == 0) break;
         advance_cycle(d_v, d_f, d_m, d_lsb, d_l);
      end
      n_checks++;
      if (exp_q.size() != 0 || fifo_q.size() != 0)
         $display("[TB] FAIL drain_timeout: beats left %0d words left %0d expected 0/0",
                  exp_q.size(), fifo_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      flush_n   = 1'b1;
      en        = 1'b1;
      out_ready = 1'b1;
      cnt_model = 16'd0;
      refresh_head();
      #2;
      n_checks++;
      if (bus_m.FOutN !== 1'b1 || bus_m.Out_Valid !== 1'b0 || bus_m.Out_Data !== 8'h00 ||
          bus_m.Pop_Cnt !== 16'd0 || bus_m.Out_Last !== 1'b0)
         $display("[TB] FAIL reset_state: fout=%b valid=%b data=%h cnt=%0d last=%b expected 1 0 00 0 0",
                  bus_m.FOutN, bus_m.Out_Valid, bus_m.Out_Data, bus_m.Pop_Cnt, bus_m.Out_Last);
      else n_pass++;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      push_word(32'h1234_5678);
      push_word(32'h9ABC_DEF0);
      for (int i = 0; i < 3; i++) advance_cycle(d_v, d_f, d_m, d_lsb, d_l);
      // Reset lands between edges while a word is held and the FIFO still has data.
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus_m.FOutN !== 1'b1 || bus_l.FOutN !== 1'b1 || bus_m.Out_Valid !== 1'b0 ||
          bus_m.Out_Data !== 8'h00 || bus_m.Pop_Cnt !== 16'd0 || bus_m.Out_Last !== 1'b0)
         $display("[TB] FAIL reset_mid: fout=%b/%b valid=%b data=%h cnt=%0d last=%b expected 1/1 0 00 0 0",
                  bus_m.FOutN, bus_l.FOutN, bus_m.Out_Valid, bus_m.Out_Data,
                  bus_m.Pop_Cnt, bus_m.Out_Last);
      else n_pass++;
      exp_q.delete();
      cnt_model = 16'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_idle(20);
   endtask

   task automatic test_single_word();
      logic [15:0] cnt0;
      logic [31:0] seq;
      int fouts, nbeats, lasts, last_at, first_v, last_v;
      logic v, f, l;
      logic [7:0] m, lb;
      cnt0 = cnt_model;
      seq = '0; fouts = 0; nbeats = 0; lasts = 0; last_at = 0; first_v = -1; last_v = -1;
      out_ready = 1'b1;
      push_word(32'hA1B2_C3D4);
      for (int i = 0; i < 7; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (!f) fouts++;
         if (v) begin
            seq = {seq[23:0], m};
            nbeats++;
            if (first_v < 0) first_v = i;
            last_v = i;
            if (l) begin lasts++; last_at = nbeats; end
         end
      end
      n_checks++;
      if (fouts != 1) $display("[TB] FAIL single_pops: got %0d expected 1", fouts);
      else n_pass++;
      n_checks++;
      if (seq !== 32'hA1B2_C3D4 || nbeats != 4 || (last_v - first_v) != 3)
         $display("[TB] FAIL single_beats: got %h n=%0d span=%0d expected a1b2c3d4 n=4 span=3",
                  seq, nbeats, last_v - first_v);
      else n_pass++;
      n_checks++;
      if (lasts != 1 || last_at != 4)
         $display("[TB] FAIL single_last: count=%0d at beat %0d expected 1 at 4", lasts, last_at);
      else n_pass++;
      n_checks++;
      if (bus_m.Pop_Cnt !== cnt0 + 16'd1 || bus_m.Out_Valid !== 1'b0)
         $display("[TB] FAIL single_after: cnt=%0d valid=%b expected %0d 0",
                  bus_m.Pop_Cnt, bus_m.Out_Valid, cnt0 + 16'd1);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int fouts, nbeats, first_v, last_v, coincide;
      logic v, f, l;
      logic [7:0] m, lb;
      fouts = 0; nbeats = 0; first_v = -1; last_v = -1; coincide = 0;
      out_ready = 1'b1;
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
      for (int i = 0; i < 12; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (!f) begin
            fouts++;
            if (v && m === 8'h44) coincide++;
         end
         if (v) begin
            nbeats++;
            if (first_v < 0) first_v = i;
            last_v = i;
         end
      end
      n_checks++;
      if (nbeats != 8 || (last_v - first_v) != 7)
         $display("[TB] FAIL b2b_gapless: beats=%0d span=%0d expected 8 7", nbeats, last_v - first_v);
      else n_pass++;
      n_checks++;
      if (fouts != 2 || coincide != 1)
         $display("[TB] FAIL b2b_overlap: pops=%0d pop_on_44=%0d expected 2 1", fouts, coincide);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic found;
      logic v, f, l;
      logic [7:0] m, lb;
      found = 1'b0;
      out_ready = 1'b1;
      push_word(32'hA1B2_C3D4);
      push_word(32'h99AA_BBCC);
      for (int i = 0; i < 10 && !found; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (v && m === 8'hA1) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("[TB] FAIL bp_find_a1: got none expected beat a1 within 10 cycles");
      else n_pass++;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         advance_cycle(v, f, m, lb, l);
         n_checks++;
         if (v !== 1'b1 || m !== 8'hB2 || f !== 1'b1)
            $display("[TB] FAIL bp_hold: valid=%b data=%h fout=%b expected 1 b2 1", v, m, f);
         else n_pass++;
      end
      out_ready = 1'b1;
      advance_cycle(v, f, m, lb, l);
      advance_cycle(v, f, m, lb, l);
      n_checks++;
      if (v !== 1'b1 || m !== 8'hC3)
         $display("[TB] FAIL bp_resume: valid=%b data=%h expected 1 c3", v, m);
      else n_pass++;
      wait_idle(20);
   endtask

   task automatic test_flush();
      logic found;
      logic [31:0] seq;
      int nbeats;
      logic v, f, l;
      logic [7:0] m, lb;
      found = 1'b0; seq = '0; nbeats = 0;
      out_ready = 1'b1;
      push_word(32'hA1B2_C3D4);
      push_word(32'hCAFE_F00D);
      for (int i = 0; i < 10 && !found; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (v && m === 8'hA1) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("[TB] FAIL flush_find_a1: got none expected beat a1 within 10 cycles");
      else n_pass++;
      flush_n = 1'b0;
      advance_cycle(v, f, m, lb, l);
      flush_n = 1'b1;
      n_checks++;
      if (bus_m.Out_Valid !== 1'b0 || bus_m.Pop_Cnt !== 16'd0 || bus_l.Pop_Cnt !== 16'd0)
         $display("[TB] FAIL flush_clear: valid=%b cnt=%0d/%0d expected 0 0/0",
                  bus_m.Out_Valid, bus_m.Pop_Cnt, bus_l.Pop_Cnt);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (v) begin
            seq = {seq[23:0], m};
            nbeats++;
         end
      end
      n_checks++;
      if (seq !== 32'hCAFE_F00D || nbeats != 4)
         $display("[TB] FAIL flush_next_word: got %h n=%0d expected cafef00d n=4", seq, nbeats);
      else n_pass++;
   endtask

   task automatic test_lsb_en();
      logic found;
      logic [15:0] cnt0;
      logic [23:0] seq;
      int nbeats, fouts;
      logic v, f, l;
      logic [7:0] m, lb;
      found = 1'b0; seq = '0; nbeats = 0; fouts = 0;
      cnt0 = cnt_model;
      en = 1'b1;
      out_ready = 1'b1;
      push_word(32'hA1B2_C3D4);
      push_word(32'h0102_0304);
      for (int i = 0; i < 10 && !found; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (v && lb === 8'hD4) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("[TB] FAIL lsb_find_d4: got none expected lsb beat d4 within 10 cycles");
      else n_pass++;
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         advance_cycle(v, f, m, lb, l);
         if (!f) fouts++;
         if (v) begin
            seq = {seq[15:0], lb};
            nbeats++;
         end
      end
      n_checks++;
      if (seq !== 24'hC3B2A1 || nbeats != 3)
         $display("[TB] FAIL lsb_order: got %h n=%0d expected c3b2a1 n=3", seq, nbeats);
      else n_pass++;
      n_checks++;
      if (fouts != 0 || bus_l.Out_Valid !== 1'b0 || bus_l.Pop_Cnt !== cnt0 + 16'd1)
         $display("[TB] FAIL en_hold_off: pops=%0d valid=%b cnt=%0d expected 0 0 %0d",
                  fouts, bus_l.Out_Valid, bus_l.Pop_Cnt, cnt0 + 16'd1);
      else n_pass++;
      en = 1'b1;
      wait_idle(20);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_lsb_en();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
